io_timer_dev: RTL and testbench

Memory-mapped interval timer that sits on the processor's 16-bit load/store path as a bus responder, next to the memory array and the KEY/SW input ports. The processor's MAR drives the address; a store presents data with a write strobe; a load reads combinationally. The block counts prescaled clock ticks up to a programmable limit and raises a sticky ready flag, plus an overflow flag for missed events and an optional interrupt line, so software can pace itself without busy-counting loops.

---
 rtl/io_timer_dev.sv | 113 +++++++++++
 tb/tb_io_timer_dev.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_timer_dev.sv
// Memory-mapped interval timer: a prescaled up-counter with a programmable wrap
// limit, a sticky ready flag, an overflow flag for missed wraps and an interrupt.
module io_timer_dev #(
  parameter int              DBITS    = 16,
  parameter logic [DBITS-1:0] BASE    = 16'hF00,
  parameter int              PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  output logic             sel,
  output logic [DBITS-1:0] rdata,
  output logic             irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [DBITS-1:0] cnt;
  logic [DBITS-1:0] lim;
  logic [PW-1:0]    pre;
  logic             en;
  logic             ie;
  logic             ready;
  logic             ovf;

  logic             wr_cnt;
  logic             wr_lim;
  logic             wr_ctl;
  logic             tick;
  logic             wrap;

  assign sel    = (addr[DBITS-1:3] == BASE[DBITS-1:3]);
  assign wr_cnt = we & sel & (addr[2:1] == 2'd0);
  assign wr_lim = we & sel & (addr[2:1] == 2'd1);
  assign wr_ctl = we & sel & (addr[2:1] == 2'd2);

  assign tick = en & (pre == PRE_LAST);
  // A software write to TCNT on the tick edge overrides the count, so no wrap.
  assign wrap = tick & ~wr_cnt & (lim != '0) & (cnt == lim - 1'b1);
  assign irq  = ready & ie;

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[2:1])
        2'd0:    rdata = cnt;
        2'd1:    rdata = lim;
        2'd2:    rdata = {{(DBITS-4){1'b0}}, ovf, ready, ie, en};
        default: rdata = DBITS'(pre);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (wr_cnt || tick) begin
      pre <= '0;
    end else if (en) begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (wr_cnt) begin
      cnt <= wdata;
    end else if (wrap) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lim <= '0;
    end else if (wr_lim) begin
      lim <= wdata;
    end
  end

  // Flags are set only by hardware; a software 0 clears them unless a set
  // event lands on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en    <= 1'b0;
      ie    <= 1'b0;
      ready <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_ctl) begin
        en <= wdata[0];
        ie <= wdata[1];
      end
      if (wrap) begin
        ready <= 1'b1;
      end else if (wr_ctl && !wdata[2]) begin
        ready <= 1'b0;
      end
      if (wrap && ready) begin
        ovf <= 1'b1;
      end else if (wr_ctl && !wdata[3]) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_timer_dev.sv
// Directed bench for io_timer_dev with PRESCALE=4 and BASE=16'hF00.
module tb_io_timer_dev;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic        sel;
  logic [15:0] rdata;
  logic        irq;

  int vecs;
  int errs;

  io_timer_dev #(.DBITS(16), .BASE(16'hF00), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .sel(sel), .rdata(rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    reset = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      rd(16'hF00 + 16'(2 * i), v);
      vecs++;
      if (v !== 16'h0000) begin
        errs++;
        $display("FAIL reset_reg%0d: got %h want 0000", i, v);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    clocks(2);
    rd(16'h0F08, v);
    vecs++;
    if (sel !== 1'b0 || v !== 16'h0000) begin
      errs++;
      $display("FAIL decode_above: sel %b rdata %h want sel 0 rdata 0000", sel, v);
    end
    rd(16'h0EFE, v);
    vecs++;
    if (sel !== 1'b0 || v !== 16'h0000) begin
      errs++;
      $display("FAIL decode_below: sel %b rdata %h want sel 0 rdata 0000", sel, v);
    end
    rd(16'h0F06, v);
    vecs++;
    if (sel !== 1'b1) begin
      errs++;
      $display("FAIL decode_in: sel %b want 1", sel);
    end
  endtask

  task automatic test_write_masks;
    logic [15:0] v;
    bus_wr(16'hF04, 16'hFFF0);
    rd(16'hF04, v);
    vecs++;
    if (v !== 16'h0000) begin
      errs++;
      $display("FAIL tctl_mask: got %h want 0000", v);
    end
    bus_wr(16'hF06, 16'hFFFF);
    rd(16'hF06, v);
    vecs++;
    if (v !== 16'h0000) begin
      errs++;
      $display("FAIL tpre_ro: got %h want 0000", v);
    end
  endtask

  task automatic test_basic_wrap;
    logic [15:0] v;
    bus_wr(16'hF02, 16'h0003);
    rd(16'hF02, v);
    vecs++;
    if (v !== 16'h0003) begin
      errs++;
      $display("FAIL tlim_wr: got %h want 0003", v);
    end
    bus_wr(16'hF04, 16'h0003);
    clocks(4);
    rd(16'hF01, v);
    vecs++;
    if (v !== 16'h0001) begin
      errs++;
      $display("FAIL cnt_step1_odd_addr: got %h want 0001", v);
    end
    clocks(4);
    rd(16'hF00, v);
    vecs++;
    if (v !== 16'h0002 || irq !== 1'b0) begin
      errs++;
      $display("FAIL cnt_step2: cnt %h irq %b want 0002 0", v, irq);
    end
    clocks(4);
    rd(16'hF00, v);
    vecs++;
    if (v !== 16'h0000) begin
      errs++;
      $display("FAIL wrap_cnt: got %h want 0000", v);
    end
    rd(16'hF04, v);
    vecs++;
    if (v !== 16'h0007 || irq !== 1'b1) begin
      errs++;
      $display("FAIL wrap_ready: tctl %h irq %b want 0007 1", v, irq);
    end
    rd(16'hF06, v);
    vecs++;
    if (v !== 16'h0000) begin
      errs++;
      $display("FAIL wrap_pre: got %h want 0000", v);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] v;
    clocks(12);
    rd(16'hF04, v);
    vecs++;
    if (v !== 16'h000F) begin
      errs++;
      $display("FAIL ovf_set: got %h want 000F", v);
    end
    bus_wr(16'hF04, 16'h0003);
    rd(16'hF04, v);
    vecs++;
    if (v !== 16'h0003 || irq !== 1'b0) begin
      errs++;
      $display("FAIL flag_clear: tctl %h irq %b want 0003 0", v, irq);
    end
  endtask

  task automatic test_clear_collision;
    logic [15:0] v;
    repeat (10) @(posedge clk);
    bus_wr(16'hF04, 16'h0003);
    rd(16'hF04, v);
    vecs++;
    if (v !== 16'h0007) begin
      errs++;
      $display("FAIL clr_vs_wrap: got %h want 0007", v);
    end
    repeat (11) @(posedge clk);
    bus_wr(16'hF04, 16'h0003);
    rd(16'hF04, v);
    vecs++;
    if (v !== 16'h000F) begin
      errs++;
      $display("FAIL clr_vs_ovf: got %h want 000F", v);
    end
  endtask

  task automatic test_cnt_collision;
    logic [15:0] v;
    repeat (3) @(posedge clk);
    bus_wr(16'hF00, 16'h0002);
    rd(16'hF00, v);
    vecs++;
    if (v !== 16'h0002) begin
      errs++;
      $display("FAIL cnt_wr_vs_tick: got %h want 0002", v);
    end
    rd(16'hF06, v);
    vecs++;
    if (v !== 16'h0000) begin
      errs++;
      $display("FAIL cnt_wr_pre: got %h want 0000", v);
    end
    clocks(3);
    rd(16'hF00, v);
    vecs++;
    if (v !== 16'h0002) begin
      errs++;
      $display("FAIL cnt_hold: got %h want 0002", v);
    end
    rd(16'hF06, v);
    vecs++;
    if (v !== 16'h0003) begin
      errs++;
      $display("FAIL pre_count: got %h want 0003", v);
    end
    clocks(1);
    rd(16'hF00, v);
    vecs++;
    if (v !== 16'h0000) begin
      errs++;
      $display("FAIL cnt_wrap_after_wr: got %h want 0000", v);
    end
  endtask

  task automatic test_free_run_reset;
    logic [15:0] v;
    bus_wr(16'hF04, 16'h0000);
    bus_wr(16'hF02, 16'h0000);
    bus_wr(16'hF00, 16'hFFFE);
    bus_wr(16'hF04, 16'h0001);
    clocks(4);
    rd(16'hF00, v);
    vecs++;
    if (v !== 16'hFFFF) begin
      errs++;
      $display("FAIL free_ffff: got %h want FFFF", v);
    end
    clocks(4);
    rd(16'hF00, v);
    vecs++;
    if (v !== 16'h0000) begin
      errs++;
      $display("FAIL free_wrap: got %h want 0000", v);
    end
    rd(16'hF04, v);
    vecs++;
    if (v !== 16'h0001) begin
      errs++;
      $display("FAIL free_no_ready: got %h want 0001", v);
    end
    clocks(2);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(16'hF00 + 16'(2 * i), v);
      vecs++;
      if (v !== 16'h0000) begin
        errs++;
        $display("FAIL async_rst_reg%0d: got %h want 0000", i, v);
      end
    end
    vecs++;
    if (irq !== 1'b0) begin
      errs++;
      $display("FAIL async_rst_irq: got %b want 0", irq);
    end
    @(negedge clk);
    reset = 1'b0;
    clocks(8);
    rd(16'hF00, v);
    vecs++;
    if (v !== 16'h0000) begin
      errs++;
      $display("FAIL idle_after_rst: got %h want 0000", v);
    end
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    reset = 1'b1;
    addr  = 16'h0000;
    wdata = 16'h0000;
    we    = 1'b0;
    test_reset;
    test_write_masks;
    test_basic_wrap;
    test_overflow;
    test_clear_collision;
    test_cnt_collision;
    test_free_run_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
